// File: rtl/flag_branch_unit_if.sv
// ---------------------------------------------------------------------------
// flag_branch_unit_if
// Bundles the EX-stage flag producer, the decode-stage branch request, the
// global pipeline controls and the unit's results into a single connection.
//   master : pipeline side (drives EX/decode/stall/flush, reads results)
//   slave  : flag_branch_unit (reads requests, drives flags/branch results)
// Signals:
//   ex_valid, ex_flag_we[2:0] {Z,N,V}, ex_z, ex_n, ex_v   EX-stage producer
//   stall, flush                                          pipeline control
//   br_valid, br_cond[2:0]                                decode branch
//   flag_z, flag_n, flag_v                                architectural flags
//   br_resolved, br_taken, flag_stall                     branch results
// ---------------------------------------------------------------------------
interface flag_branch_unit_if;
    logic       ex_valid;
    logic [2:0] ex_flag_we;
    logic       ex_z;
    logic       ex_n;
    logic       ex_v;
    logic       stall;
    logic       flush;
    logic       br_valid;
    logic [2:0] br_cond;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic       br_resolved;
    logic       br_taken;
    logic       flag_stall;

    modport master (
        output ex_valid, ex_flag_we, ex_z, ex_n, ex_v,
        output stall, flush, br_valid, br_cond,
        input  flag_z, flag_n, flag_v, br_resolved, br_taken, flag_stall
    );

    modport slave (
        input  ex_valid, ex_flag_we, ex_z, ex_n, ex_v,
        input  stall, flush, br_valid, br_cond,
        output flag_z, flag_n, flag_v, br_resolved, br_taken, flag_stall
    );
endinterface

// File: rtl/flag_branch_unit.sv
// ---------------------------------------------------------------------------
// flag_branch_unit
// Holds the architectural Z/N/V flag register fed by the ALU at the EX/MEM
// boundary and resolves decode-stage conditional branches against it.
// When the instruction in EX writes any flag while a branch sits in decode,
// the branch either waits one cycle for the flags to land (FWD_EN=0) or
// sees the ALU flags forwarded combinationally (FWD_EN=1).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    flag_branch_unit_if.slave (see interface header)
// Parameters:
//   FLAG_RST  reset value of {Z,N,V}
//   FWD_EN    0 = one-cycle interlock on the flag hazard, 1 = forwarding
// ---------------------------------------------------------------------------
module flag_branch_unit #(
    parameter logic [2:0] FLAG_RST = 3'b000,
    parameter bit         FWD_EN   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    flag_branch_unit_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] flags_reg;
    logic [2:0] alu_flags;
    logic [2:0] eff_flags;
    logic       flag_write;
    logic       hazard;
    logic       can_resolve;
    logic       resolve_next;
    logic       stall_req_next;
    logic       cond_true;

    assign alu_flags   = {bus.ex_z, bus.ex_n, bus.ex_v};
    assign flag_write  = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign hazard      = bus.br_valid & bus.ex_valid & (|bus.ex_flag_we) & ~bus.flush;
    assign can_resolve = bus.br_valid & ~bus.stall & ~bus.flush;

    // Flag register: only the flags selected by the write mask take the
    // ALU result; the rest keep their previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= FLAG_RST;
        end else if (flag_write) begin
            flags_reg <= (flags_reg & ~bus.ex_flag_we) | (alu_flags & bus.ex_flag_we);
        end
    end

    // Effective flags seen by the branch. In forwarding mode a flag being
    // written by the EX instruction is taken straight from the ALU.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_eff
            assign eff_flags[gi] = (FWD_EN && bus.ex_valid && bus.ex_flag_we[gi])
                                   ? alu_flags[gi] : flags_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // WAIT means the producer has just written the flag register, so the
    // held branch can now be evaluated on registered flags. WAIT always
    // drops back to IDLE on an advancing edge, so a second producer right
    // behind cannot re-interlock the same branch.
    always_comb begin
        state_next     = state_reg;
        resolve_next   = 1'b0;
        stall_req_next = 1'b0;
        if (FWD_EN) begin
            state_next   = IDLE;
            resolve_next = can_resolve;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hazard) begin
                        stall_req_next = 1'b1;
                        if (!bus.stall) begin
                            state_next = WAIT;
                        end
                    end else begin
                        resolve_next = can_resolve;
                    end
                end
                WAIT: begin
                    resolve_next = can_resolve;
                    if (bus.flush || !bus.stall) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // eff_flags bit order: [2]=Z, [1]=N, [0]=V
    always_comb begin
        cond_true = 1'b0;
        case (bus.br_cond)
            3'b000:  cond_true = ~eff_flags[2];
            3'b001:  cond_true =  eff_flags[2];
            3'b010:  cond_true = ~eff_flags[2] & ~eff_flags[1];
            3'b011:  cond_true =  eff_flags[1];
            3'b100:  cond_true =  eff_flags[2] | ~eff_flags[1];
            3'b101:  cond_true =  eff_flags[2] |  eff_flags[1];
            3'b110:  cond_true =  eff_flags[0];
            default: cond_true = 1'b1;
        endcase
    end

    // Results are combinational; gating with rst_n keeps them low for the
    // whole reset window regardless of what decode presents.
    assign bus.br_resolved = resolve_next & rst_n;
    assign bus.br_taken    = resolve_next & rst_n & cond_true;
    assign bus.flag_stall  = stall_req_next & rst_n;
    assign bus.flag_z      = flags_reg[2];
    assign bus.flag_n      = flags_reg[1];
    assign bus.flag_v      = flags_reg[0];

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sits directly downstream of the 16-bit ALU (zFlag/nFlag/vFlag producer) at the EX/MEM boundary.
- Holds the architectural Z/N/V flag register and updates it per-instruction under a write mask supplied by decode.
- Resolves conditional branches in decode against the flags, with an interlock FSM for the flag-producer-in-EX hazard.
- Honours global pipeline stall and flush.

Parameters:
- FLAG_RST, 3'b000: reset value of {Z,N,V}.
- FWD_EN, 0: 0 = interlock on hazard (one-cycle stall); 1 = forward the ALU flags combinationally into branch evaluation with no stall.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_flag_we  in  3  per-flag write enable {Z,N,V} for the EX instruction.
- ex_z  in  1  ALU zFlag.
- ex_n  in  1  ALU nFlag.
- ex_v  in  1  ALU vFlag.
- stall  in  1  global pipeline stall; hold all state.
- flush  in  1  squash EX instruction and pending branch.
- br_valid  in  1  decode holds a conditional branch.
- br_cond  in  3  condition code.
- flag_z  out  1  registered Z flag.
- flag_n  out  1  registered N flag.
- flag_v  out  1  registered V flag.
- br_resolved  out  1  br_taken is valid this cycle.
- br_taken  out  1  branch condition true; meaningful only when br_resolved=1.
- flag_stall  out  1  request decode/fetch hold for the flag hazard.

Behaviour:
- Reset (async, rst_n=0):
  - {flag_z,flag_n,flag_v}=FLAG_RST.
  - FSM=IDLE.
  - br_resolved=0, br_taken=0, flag_stall=0.
- Flag update: at posedge, when ex_valid & ~stall & ~flush, each flag whose ex_flag_we bit is 1 loads its ALU flag. Bits with we=0 hold. Otherwise all flags hold.
- Condition codes, evaluated on the effective flags F:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | N=0
  - 101 LTE: Z=1 | N=1
  - 110 OVF: V=1
  - 111 UNCOND: always 1
- hazard = br_valid & ex_valid & (ex_flag_we != 0) & ~flush.
- FSM (FWD_EN=0): states IDLE and WAIT.
  - IDLE, ~hazard: br_resolved=br_valid & ~stall & ~flush. F = registered flags.
  - IDLE, hazard: flag_stall=1 (combinational, same cycle), br_resolved=0. Next state WAIT if ~stall.
  - WAIT: flag register now holds the producer's result. flag_stall=0. br_resolved=br_valid & ~stall & ~flush. F = registered flags.
  - WAIT exits to IDLE on the next non-stalled edge, or immediately on flush.
  - WAIT with br_valid=0 (branch squashed upstream): no resolve; return to IDLE.
  - Any state with stall=1: FSM, flags and outputs hold their decision. br_resolved is forced 0. flag_stall keeps its IDLE-hazard value.
- FWD_EN=1:
  - FSM stays IDLE; flag_stall=0 always.
  - F per bit = ex_flag_we[i]&ex_valid ? ALU flag : registered flag.
  - br_resolved=br_valid & ~stall & ~flush.
- Flush has priority over stall and over update: no flag write, FSM→IDLE, br_resolved=0, flag_stall=0.
- Back-to-back flag producers: each updates in order; only the producer immediately ahead of a branch causes the interlock.
- br_taken=0 whenever br_resolved=0.

Test Plan:
- Reset: rst_n low mid-cycle, flags previously 3'b111 → all outputs 0 immediately, asynchronously, with FLAG_RST=000.
- Masked update: ex_valid=1, ex_flag_we=3'b100, ALU {z,n,v}=111, prior flags 000 → after the edge flags {1,0,0}. Next op we=3'b011, ALU {0,1,1} → flags {1,1,1}.
- Hazard interlock (FWD_EN=0):
  - Stimulus: flags Z=0; EX writes Z=1 (we=100) while br_valid=1, br_cond=001.
  - Cycle 0: flag_stall=1, br_resolved=0.
  - Cycle 1 (WAIT): flag_stall=0, br_resolved=1, br_taken=1.
- No hazard: ex_flag_we=000, flags N=1, br_cond=011 → same-cycle br_resolved=1, br_taken=1. br_cond=010 → br_taken=0.
- Stall/flush:
  - stall=1 during WAIT for 3 cycles → state held, br_resolved=0; resolves on the first cycle with stall=0.
  - flush=1 with ex_valid, we=111 → flags unchanged, FSM IDLE, no resolve.
- Forward mode (FWD_EN=1): same stimulus as the hazard test → flag_stall=0, br_resolved=1, br_taken=1 in cycle 0. br_cond=110 with ALU v=1, we=001 → br_taken=1.
